// File: rtl/pc_update_if.sv
// Signal bundle between the multicycle datapath/control and the PC update unit.
interface pc_update_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 pc_write;
  logic                 pc_write_cond;
  logic [2:0]           cond_sel;
  logic                 zero;
  logic                 gt;
  logic [WIDTH-1:0]     next_pc;
  logic                 exc_req;
  logic                 eret;
  logic [WIDTH-1:0]     pc_out;
  logic [WIDTH-1:0]     epc_out;
  logic                 pc_wr_en;
  logic                 branch_taken;
  logic                 misalign;
  logic [CNT_WIDTH-1:0] taken_count;

  // Datapath/control side: drives requests, observes PC state.
  modport master (
    output pc_write, pc_write_cond, cond_sel, zero, gt, next_pc, exc_req, eret,
    input  pc_out, epc_out, pc_wr_en, branch_taken, misalign, taken_count
  );

  // PC update unit side.
  modport slave (
    input  pc_write, pc_write_cond, cond_sel, zero, gt, next_pc, exc_req, eret,
    output pc_out, epc_out, pc_wr_en, branch_taken, misalign, taken_count
  );
endinterface

// File: rtl/pc_update_unit.sv
// Program-counter register with conditional-branch decode, EPC capture/return,
// misaligned-target trap and a saturating taken-branch debug counter.
module pc_update_unit #(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_00FC),
  parameter int              CNT_WIDTH    = 16
) (
  input  logic        clk,
  input  logic        reset,
  pc_update_if.slave  bus
);

  typedef enum logic [2:0] {
    C_NEVER  = 3'b000,
    C_EQ     = 3'b001,
    C_NE     = 3'b010,
    C_GT     = 3'b011,
    C_LE     = 3'b100,
    C_LT     = 3'b101,
    C_GE     = 3'b110,
    C_ALWAYS = 3'b111
  } cond_e;

  logic [WIDTH-1:0]     pc_q;
  logic [WIDTH-1:0]     epc_q;
  logic                 branch_taken_q;
  logic                 misalign_q;
  logic [CNT_WIDTH-1:0] taken_count_q;

  logic cond_met;
  logic cond_taken;
  logic wr_req;
  logic aligned;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + 1'b1;
  endfunction

  always_comb begin
    cond_met = 1'b0;
    case (cond_e'(bus.cond_sel))
      C_NEVER:  cond_met = 1'b0;
      C_EQ:     cond_met = bus.zero;
      C_NE:     cond_met = ~bus.zero;
      C_GT:     cond_met = bus.gt;
      C_LE:     cond_met = ~bus.gt;
      C_LT:     cond_met = ~bus.gt & ~bus.zero;
      C_GE:     cond_met = bus.gt | bus.zero;
      C_ALWAYS: cond_met = 1'b1;
      default:  cond_met = 1'b0;
    endcase
  end

  assign cond_taken = bus.pc_write_cond & cond_met;
  assign wr_req     = bus.pc_write | cond_taken;
  assign aligned    = (bus.next_pc[1:0] == 2'b00);

  // Exceptions and returns pre-empt any write; misaligned targets trap instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_VECTOR;
      epc_q          <= '0;
      branch_taken_q <= 1'b0;
      misalign_q     <= 1'b0;
      taken_count_q  <= '0;
    end else begin
      branch_taken_q <= 1'b0;
      misalign_q     <= 1'b0;
      if (bus.exc_req) begin
        pc_q  <= EXC_VECTOR;
        epc_q <= pc_q;
      end else if (bus.eret) begin
        pc_q <= epc_q;
      end else if (wr_req && !aligned) begin
        pc_q       <= EXC_VECTOR;
        epc_q      <= bus.next_pc;
        misalign_q <= 1'b1;
      end else if (wr_req) begin
        pc_q <= bus.next_pc;
        if (cond_taken) begin
          branch_taken_q <= 1'b1;
          taken_count_q  <= sat_inc(taken_count_q);
        end
      end
    end
  end

  assign bus.pc_wr_en     = ~bus.exc_req & ~bus.eret & wr_req & aligned;
  assign bus.pc_out       = pc_q;
  assign bus.epc_out      = epc_q;
  assign bus.branch_taken = branch_taken_q;
  assign bus.misalign     = misalign_q;
  assign bus.taken_count  = taken_count_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: vector table, condition sweep, saturation and reset corners.
module tb_pc_update_unit;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_update_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_W)) bus ();

  pc_update_unit #(
    .WIDTH(WIDTH),
    .RESET_VECTOR(32'h0000_0000),
    .EXC_VECTOR(32'h0000_00FC),
    .CNT_WIDTH(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic        pcw;
    logic        pcwc;
    logic [2:0]  cond;
    logic        z;
    logic        g;
    logic [31:0] np;
    logic        exc;
    logic        eret;
    logic        exp_wr;
    logic [31:0] exp_pc;
    logic [31:0] exp_epc;
    logic        exp_bt;
    logic        exp_mis;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[16];
  int total = 0;
  int bad   = 0;

  // Decode table indexed [cond_sel][{zero,gt}].
  logic [3:0] ctab [8];
  int model_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pcw, input logic pcwc, input logic [2:0] cond,
                       input logic z, input logic g, input logic [31:0] np,
                       input logic exc, input logic er);
    bus.pc_write      = pcw;
    bus.pc_write_cond = pcwc;
    bus.cond_sel      = cond;
    bus.zero          = z;
    bus.gt            = g;
    bus.next_pc       = np;
    bus.exc_req       = exc;
    bus.eret          = er;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 3'b000, 0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    ctab[0] = 4'b0000; // NEVER
    ctab[1] = 4'b1100; // EQ: zero
    ctab[2] = 4'b0011; // NE: ~zero
    ctab[3] = 4'b1010; // GT: gt
    ctab[4] = 4'b0101; // LE: ~gt
    ctab[5] = 4'b0001; // LT: ~gt & ~zero
    ctab[6] = 4'b1110; // GE: gt | zero
    ctab[7] = 4'b1111; // ALWAYS

    //               pcw pcwc cond    z  g  np            exc er  wr  pc            epc           bt mis cnt
    vecs[0]  = '{1, 0, 3'b000, 0, 0, 32'h10,  0, 0, 1, 32'h10,  32'h0,   0, 0, 4'd0};
    vecs[1]  = '{1, 0, 3'b000, 0, 0, 32'h24,  0, 0, 1, 32'h24,  32'h0,   0, 0, 4'd0};
    vecs[2]  = '{1, 0, 3'b000, 0, 0, 32'h40,  1, 0, 0, 32'hFC,  32'h24,  0, 0, 4'd0};
    vecs[3]  = '{0, 0, 3'b000, 0, 0, 32'h0,   0, 1, 0, 32'h24,  32'h24,  0, 0, 4'd0};
    vecs[4]  = '{0, 0, 3'b000, 0, 0, 32'h0,   1, 1, 0, 32'hFC,  32'h24,  0, 0, 4'd0};
    vecs[5]  = '{0, 0, 3'b000, 0, 0, 32'h0,   0, 1, 0, 32'h24,  32'h24,  0, 0, 4'd0};
    vecs[6]  = '{1, 0, 3'b000, 0, 0, 32'h102, 0, 0, 0, 32'hFC,  32'h102, 0, 1, 4'd0};
    vecs[7]  = '{0, 0, 3'b000, 0, 0, 32'h0,   0, 0, 0, 32'hFC,  32'h102, 0, 0, 4'd0};
    vecs[8]  = '{0, 1, 3'b101, 0, 0, 32'h80,  0, 0, 1, 32'h80,  32'h102, 1, 0, 4'd1};
    vecs[9]  = '{0, 0, 3'b000, 0, 0, 32'h0,   0, 0, 0, 32'h80,  32'h102, 0, 0, 4'd1};
    vecs[10] = '{0, 1, 3'b101, 1, 0, 32'h90,  0, 0, 0, 32'h80,  32'h102, 0, 0, 4'd1};
    vecs[11] = '{1, 1, 3'b111, 0, 0, 32'h88,  0, 0, 1, 32'h88,  32'h102, 1, 0, 4'd2};
    vecs[12] = '{0, 1, 3'b111, 0, 0, 32'h8A,  0, 0, 0, 32'hFC,  32'h8A,  0, 1, 4'd2};
    vecs[13] = '{0, 1, 3'b001, 1, 0, 32'h40,  1, 0, 0, 32'hFC,  32'hFC,  0, 0, 4'd2};
    vecs[14] = '{0, 0, 3'b000, 0, 0, 32'h0,   0, 1, 0, 32'hFC,  32'hFC,  0, 0, 4'd2};
    vecs[15] = '{1, 0, 3'b000, 0, 0, 32'h0,   0, 0, 1, 32'h0,   32'hFC,  0, 0, 4'd2};

    // Reset overrides a simultaneous write.
    reset = 1'b1;
    drive(1, 0, 3'b000, 0, 0, 32'h40, 0, 0);
    tick();
    tick();
    chk("rst_pc",  bus.pc_out, 32'h0);
    chk("rst_epc", bus.epc_out, 32'h0);
    chk("rst_bt",  {31'b0, bus.branch_taken}, 32'h0);
    chk("rst_mis", {31'b0, bus.misalign}, 32'h0);
    chk("rst_cnt", {28'b0, bus.taken_count}, 32'h0);
    reset = 1'b0;
    idle();
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].pcw, vecs[i].pcwc, vecs[i].cond, vecs[i].z, vecs[i].g,
            vecs[i].np, vecs[i].exc, vecs[i].eret);
      #1;
      chk($sformatf("v%0d_wr_en", i), {31'b0, bus.pc_wr_en}, {31'b0, vecs[i].exp_wr});
      tick();
      chk($sformatf("v%0d_pc", i),  bus.pc_out,  vecs[i].exp_pc);
      chk($sformatf("v%0d_epc", i), bus.epc_out, vecs[i].exp_epc);
      chk($sformatf("v%0d_bt", i),  {31'b0, bus.branch_taken}, {31'b0, vecs[i].exp_bt});
      chk($sformatf("v%0d_mis", i), {31'b0, bus.misalign}, {31'b0, vecs[i].exp_mis});
      chk($sformatf("v%0d_cnt", i), {28'b0, bus.taken_count}, {28'b0, vecs[i].exp_cnt});
    end

    // Sweep every condition code against every flag combination.
    model_cnt = 2;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 4; f++) begin
        logic [2:0] cs;
        logic [3:0] row;
        logic met;
        cs  = 3'(c);
        row = ctab[c];
        met = row[f];
        drive(1, 0, 3'b000, 0, 0, 32'h4, 0, 0);
        tick();
        drive(0, 1, cs, f[1], f[0], 32'h80, 0, 0);
        #1;
        chk($sformatf("sw%0d_%0d_wr_en", c, f), {31'b0, bus.pc_wr_en}, {31'b0, met});
        tick();
        if (met && model_cnt < 15) model_cnt++;
        chk($sformatf("sw%0d_%0d_pc", c, f), bus.pc_out, met ? 32'h80 : 32'h4);
        chk($sformatf("sw%0d_%0d_bt", c, f), {31'b0, bus.branch_taken}, {31'b0, met});
        chk($sformatf("sw%0d_%0d_mis", c, f), {31'b0, bus.misalign}, 32'h0);
        chk($sformatf("sw%0d_%0d_cnt", c, f), {28'b0, bus.taken_count}, 32'(model_cnt));
      end
    end

    // 17 taken branches from a fresh reset saturate a 4-bit counter at 15.
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    chk("sat_rst_cnt", {28'b0, bus.taken_count}, 32'h0);
    for (int k = 0; k < 17; k++) begin
      drive(0, 1, 3'b111, 0, 0, 32'(16 * (k + 1)), 0, 0);
      tick();
      if (k == 14) chk("sat_cnt15", {28'b0, bus.taken_count}, 32'd15);
    end
    chk("sat_cnt_hold", {28'b0, bus.taken_count}, 32'd15);
    chk("sat_pc", bus.pc_out, 32'h110);
    chk("sat_bt", {31'b0, bus.branch_taken}, 32'h1);

    // Reset right after a taken branch clears the pulse and the counter.
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    chk("rst_bt_pulse", {31'b0, bus.branch_taken}, 32'h0);
    chk("rst_cnt_sat",  {28'b0, bus.taken_count}, 32'h0);

    // Trap, then reset on the following cycle.
    drive(1, 0, 3'b000, 0, 0, 32'h203, 0, 0);
    tick();
    chk("trap_mis", {31'b0, bus.misalign}, 32'h1);
    chk("trap_pc",  bus.pc_out, 32'hFC);
    chk("trap_epc", bus.epc_out, 32'h203);
    reset = 1'b1;
    drive(1, 0, 3'b000, 0, 0, 32'h301, 0, 0);
    tick();
    reset = 1'b0;
    idle();
    chk("trap_rst_mis", {31'b0, bus.misalign}, 32'h0);
    chk("trap_rst_pc",  bus.pc_out, 32'h0);
    chk("trap_rst_epc", bus.epc_out, 32'h0);
    tick();
    chk("idle_pc_hold", bus.pc_out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
